// File: rtl/cpu_mem_responder.sv
// -----------------------------------------------------------------------------
// cpu_mem_responder
//   Memory-side responder for the basic CPU bus. Owns the unified program/data
//   RAM, preloads a program from a byte stream while holding the CPU in reset,
//   serves CPU reads/writes while the CPU runs, then freezes the CPU and streams
//   a result window out through a valid/ready dump port.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   rd_mem, wr_mem    CPU read / write strobes
//   adr_bus           CPU address
//   data_bus_out      CPU write data
//   data_bus_in       CPU read data (combinational, zero latency, 0 when idle)
//   cpu_rst           active-high reset to the CPU (low only while running)
//   ld_valid/ld_data/ld_last/ld_ready   program load byte stream
//   dump_start        request the result dump (honoured only while running)
//   dump_valid/dump_addr/dump_data/dump_ready   result dump stream
//   dump_done         set once the final dump beat has been consumed
// -----------------------------------------------------------------------------
module cpu_mem_responder #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8,
    parameter int DUMP_LO = 32,
    parameter int DUMP_HI = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_mem,
    input  logic              wr_mem,
    input  logic [ADDR_W-1:0] adr_bus,
    input  logic [DATA_W-1:0] data_bus_out,
    output logic [DATA_W-1:0] data_bus_in,
    output logic              cpu_rst,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              dump_start,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    input  logic              dump_ready,
    output logic              dump_done
);

    localparam int                DEPTH       = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LP_PTR_MAX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] LP_DUMP_LO  = ADDR_W'(DUMP_LO);
    localparam logic [ADDR_W-1:0] LP_DUMP_HI  = ADDR_W'(DUMP_HI);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DUMP,
        ST_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_dump_addr;

    logic              w_ld_fire;
    logic              w_dump_fire;
    logic              w_cpu_wr;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking (=) is reserved for the combinational block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next_state;
    end

    // -------------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        cpu_rst      = 1'b1;
        ld_ready     = 1'b0;
        dump_valid   = 1'b0;
        dump_done    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                ld_ready = 1'b1;
                if (ld_valid) w_next_state = ld_last ? ST_RUN : ST_LOAD;
            end
            ST_LOAD: begin
                ld_ready = 1'b1;
                // The top RAM byte ends the load even without ld_last: no wrap.
                if (ld_valid && (ld_last || r_ptr == LP_PTR_MAX))
                    w_next_state = ST_RUN;
            end
            ST_RUN: begin
                cpu_rst = 1'b0;
                if (dump_start) w_next_state = ST_DUMP;
            end
            ST_DUMP: begin
                dump_valid = 1'b1;
                if (dump_ready && r_dump_addr == LP_DUMP_HI)
                    w_next_state = ST_DONE;
            end
            ST_DONE: begin
                dump_done = 1'b1;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_ld_fire   = ld_valid & ld_ready;
    assign w_dump_fire = dump_valid & dump_ready;
    assign w_cpu_wr    = (r_state == ST_RUN) & wr_mem;

    // Load and CPU writes live in disjoint states, so one write port suffices.
    assign w_mem_we    = w_ld_fire | w_cpu_wr;
    assign w_mem_waddr = w_cpu_wr ? adr_bus      : r_ptr;
    assign w_mem_wdata = w_cpu_wr ? data_bus_out : ld_data;

    // -------------------------------------------------------------------------
    // Load pointer and dump address
    // -------------------------------------------------------------------------
    // r_ptr is 0 whenever the FSM is in IDLE, so the first byte lands at mem[0].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           r_ptr <= '0;
        else if (w_ld_fire) r_ptr <= r_ptr + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_dump_addr <= '0;
        else if (r_state == ST_RUN && dump_start)
            r_dump_addr <= LP_DUMP_LO;
        else if (w_dump_fire)
            r_dump_addr <= r_dump_addr + 1'b1;
    end

    // -------------------------------------------------------------------------
    // RAM
    // -------------------------------------------------------------------------
    // NOTE: the RAM array has no reset; an aborted operation must keep the
    // bytes already written, and leaving it out keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
    end

    // Read-during-write returns the old contents: the read is combinational
    // and the write only lands at the edge.
    assign data_bus_in = (r_state == ST_RUN && rd_mem) ? r_mem[adr_bus] : '0;
    assign dump_addr   = r_dump_addr;
    assign dump_data   = r_mem[r_dump_addr];

endmodule

// File: tb/tb_cpu_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_cpu_mem_responder
//   Directed self-checking bench for cpu_mem_responder. Inputs change 1 ns
//   after a rising edge; outputs are sampled 1 ns after that, well away from
//   the next edge.
// -----------------------------------------------------------------------------
module tb_cpu_mem_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd_mem, wr_mem;
    logic [5:0] adr_bus;
    logic [7:0] data_bus_out;
    logic [7:0] data_bus_in;
    logic       cpu_rst;
    logic       ld_valid, ld_last, ld_ready;
    logic [7:0] ld_data;
    logic       dump_start, dump_valid, dump_ready, dump_done;
    logic [5:0] dump_addr;
    logic [7:0] dump_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cpu_mem_responder #(.ADDR_W(6), .DATA_W(8), .DUMP_LO(32), .DUMP_HI(40)) dut (
        .clk(clk), .rst(rst),
        .rd_mem(rd_mem), .wr_mem(wr_mem), .adr_bus(adr_bus),
        .data_bus_out(data_bus_out), .data_bus_in(data_bus_in),
        .cpu_rst(cpu_rst),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .dump_start(dump_start), .dump_valid(dump_valid), .dump_addr(dump_addr),
        .dump_data(dump_data), .dump_ready(dump_ready), .dump_done(dump_done)
    );

    // Advance one rising edge, land 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        ld_valid = 1'b1; ld_data = d; ld_last = last;
        step();
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic cpu_write(input logic [5:0] a, input logic [7:0] d);
        wr_mem = 1'b1; adr_bus = a; data_bus_out = d;
        step();
        wr_mem = 1'b0;
    endtask

    // Read through the combinational path and compare, within the same cycle.
    task automatic cpu_read_check(input string name, input logic [5:0] a, input logic [7:0] exp);
        rd_mem = 1'b1; adr_bus = a;
        #1;
        n_tests++;
        if (data_bus_in !== exp) begin
            $display("FAIL %s: data_bus_in=%h expected %h", name, data_bus_in, exp);
            n_fail++;
        end
        rd_mem = 1'b0;
        step();
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rd_mem = 0; wr_mem = 0; adr_bus = '0; data_bus_out = '0;
        ld_valid = 0; ld_data = '0; ld_last = 0;
        dump_start = 0; dump_ready = 0;
        apply_reset();
        n_tests++;
        if ({cpu_rst, ld_ready, dump_valid, dump_done} !== 4'b1100 || dump_addr !== 6'd0) begin
            $display("FAIL reset: cpu_rst/ld_ready/dump_valid/dump_done=%b dump_addr=%0d expected 1100/0",
                     {cpu_rst, ld_ready, dump_valid, dump_done}, dump_addr);
            n_fail++;
        end
    endtask

    // Scenario 1: three-byte load with a gap cycle, cpu_rst falls after the last accept.
    task automatic test_load();
        load_byte(8'h11, 1'b0);
        step();                       // ld_valid=0 cycle: nothing changes
        load_byte(8'h22, 1'b0);
        ld_valid = 1'b1; ld_data = 8'h33; ld_last = 1'b1;
        #1;
        n_tests++;
        if (cpu_rst !== 1'b1 || ld_ready !== 1'b1) begin
            $display("FAIL load_before_last: cpu_rst=%b ld_ready=%b expected 1 1", cpu_rst, ld_ready);
            n_fail++;
        end
        step();
        ld_valid = 1'b0; ld_last = 1'b0;
        n_tests++;
        if (cpu_rst !== 1'b0 || ld_ready !== 1'b0) begin
            $display("FAIL load_enter_run: cpu_rst=%b ld_ready=%b expected 0 0", cpu_rst, ld_ready);
            n_fail++;
        end
        cpu_read_check("load_mem0", 6'd0, 8'h11);
        cpu_read_check("load_mem1", 6'd1, 8'h22);
        cpu_read_check("load_mem2", 6'd2, 8'h33);
    endtask

    // Scenario 2: write then read back; read strobe low returns zero.
    task automatic test_rw();
        cpu_write(6'd33, 8'h05);
        cpu_read_check("rw_readback", 6'd33, 8'h05);
        adr_bus = 6'd33; rd_mem = 1'b0;
        #1;
        n_tests++;
        if (data_bus_in !== 8'h00) begin
            $display("FAIL rw_rd_low: data_bus_in=%h expected 00", data_bus_in);
            n_fail++;
        end
    endtask

    // Scenario 3: simultaneous read and write returns old data that cycle.
    task automatic test_rw_same();
        cpu_write(6'd34, 8'h07);
        rd_mem = 1'b1; wr_mem = 1'b1; adr_bus = 6'd34; data_bus_out = 8'h09;
        #1;
        n_tests++;
        if (data_bus_in !== 8'h07) begin
            $display("FAIL rw_same_old: data_bus_in=%h expected 07", data_bus_in);
            n_fail++;
        end
        step();
        wr_mem = 1'b0;
        #1;
        n_tests++;
        if (data_bus_in !== 8'h09) begin
            $display("FAIL rw_same_new: data_bus_in=%h expected 09", data_bus_in);
            n_fail++;
        end
        rd_mem = 1'b0;
        step();
    endtask

    // Scenario 4: fill the window, dump it with dump_ready toggling 0/1.
    task automatic test_dump();
        logic [7:0] fib [9] = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34};
        for (int i = 0; i < 9; i++) cpu_write(6'(32 + i), fib[i]);
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            dump_ready = 1'b0;
            #1;
            n_tests++;
            if (dump_valid !== 1'b1 || dump_addr !== 6'(32 + k) || dump_data !== fib[k] || cpu_rst !== 1'b1) begin
                $display("FAIL dump_beat%0d_hold: valid=%b addr=%0d data=%0d cpu_rst=%b expected 1 %0d %0d 1",
                         k, dump_valid, dump_addr, dump_data, cpu_rst, 32 + k, fib[k]);
                n_fail++;
            end
            step();
            dump_ready = 1'b1;
            #1;
            n_tests++;
            if (dump_valid !== 1'b1 || dump_addr !== 6'(32 + k) || dump_data !== fib[k]) begin
                $display("FAIL dump_beat%0d_stable: valid=%b addr=%0d data=%0d expected 1 %0d %0d",
                         k, dump_valid, dump_addr, dump_data, 32 + k, fib[k]);
                n_fail++;
            end
            step();
        end
        dump_ready = 1'b0;
        rd_mem = 1'b1; adr_bus = 6'd32;
        #1;
        n_tests++;
        if (dump_done !== 1'b1 || dump_valid !== 1'b0 || cpu_rst !== 1'b1 || data_bus_in !== 8'h00) begin
            $display("FAIL dump_done: done=%b valid=%b cpu_rst=%b data_bus_in=%h expected 1 0 1 00",
                     dump_done, dump_valid, cpu_rst, data_bus_in);
            n_fail++;
        end
        rd_mem = 1'b0;
        step();
    endtask

    // Scenario 5: 64-byte load without ld_last stops at the top address.
    task automatic test_full_load();
        apply_reset();
        for (int i = 0; i < 63; i++) load_byte(8'(i) ^ 8'h5A, 1'b0);
        ld_valid = 1'b1; ld_data = 8'h3F ^ 8'h5A; ld_last = 1'b0;
        #1;
        n_tests++;
        if (ld_ready !== 1'b1 || cpu_rst !== 1'b1) begin
            $display("FAIL full_before_top: ld_ready=%b cpu_rst=%b expected 1 1", ld_ready, cpu_rst);
            n_fail++;
        end
        step();
        ld_data = 8'hFF;              // keep ld_valid high: must be ignored now
        #1;
        n_tests++;
        if (ld_ready !== 1'b0 || cpu_rst !== 1'b0) begin
            $display("FAIL full_enter_run: ld_ready=%b cpu_rst=%b expected 0 0", ld_ready, cpu_rst);
            n_fail++;
        end
        step();
        ld_valid = 1'b0;
        cpu_read_check("full_mem0", 6'd0, 8'h5A);
        cpu_read_check("full_mem63", 6'd63, 8'h65);
    endtask

    // Scenario 6: abort mid-load, IDLE ignores CPU writes and dump_start, reload.
    task automatic test_abort_reload();
        apply_reset();
        load_byte(8'hA1, 1'b0);
        load_byte(8'hA2, 1'b0);
        #2;
        rst = 1'b0;                   // asynchronous, mid-cycle
        #1;
        n_tests++;
        if (cpu_rst !== 1'b1 || ld_ready !== 1'b1) begin
            $display("FAIL abort_async: cpu_rst=%b ld_ready=%b expected 1 1", cpu_rst, ld_ready);
            n_fail++;
        end
        step();
        rst = 1'b1;
        step();
        cpu_write(6'd40, 8'hEE);      // IDLE: must not write
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        n_tests++;
        if (dump_valid !== 1'b0 || ld_ready !== 1'b1 || cpu_rst !== 1'b1) begin
            $display("FAIL idle_dump_ignored: dump_valid=%b ld_ready=%b cpu_rst=%b expected 0 1 1",
                     dump_valid, ld_ready, cpu_rst);
            n_fail++;
        end
        load_byte(8'hAA, 1'b1);
        n_tests++;
        if (cpu_rst !== 1'b0) begin
            $display("FAIL reload_run: cpu_rst=%b expected 0", cpu_rst);
            n_fail++;
        end
        cpu_read_check("reload_mem0", 6'd0, 8'hAA);
        cpu_read_check("reload_mem1", 6'd1, 8'hA2);
        cpu_read_check("reload_mem2", 6'd2, 8'h58);
        cpu_read_check("idle_no_write", 6'd40, 8'h72);
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_load();
        test_rw();
        test_rw_same();
        test_dump();
        test_full_load();
        test_abort_reload();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
